// File: rtl/codec_pkg.sv
// codec_pkg: shared types and constants for the codec register access arbiter.
// Holds the arbiter FSM state enum, the latched command type, a few codec
// register addresses and the default transaction watchdog limit.
package codec_pkg;

    // Widest register address the command type can carry; the arbiter's
    // ADDR_W parameter must not exceed this.
    localparam int CODEC_ADDR_W = 9;

    // Default watchdog limit per transaction (used when CODEC_ARB_TIMEOUT_EN is defined).
    localparam logic [15:0] CODEC_TIMEOUT_DEFAULT = 16'd50000;

    // Codec register map entries touched by the init unit and software.
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_CHIP_ID   = 9'h000;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_DAC_VOL   = 9'h001;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_ADC_VOL   = 9'h002;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_POWER     = 9'h004;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_SOFT_RST  = 9'h00F;

    // Arbiter sequencing: pick a port, strobe the controller, wait for it to
    // start, wait for it to finish, report back to the owner port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } arb_state_e;

    // One latched request: rd=1 read, rd=0 write.
    typedef struct packed {
        logic                    rd;
        logic [CODEC_ADDR_W-1:0] addr;
        logic [7:0]              data;
    } codec_cmd_t;

endpackage

// File: rtl/codec_req_latch.sv
// codec_req_latch: one requester port's pending-command latch.
// A rd/wr pulse on an idle port captures the command and raises busy; further
// pulses are ignored until the arbiter releases the port after its response.
module codec_req_latch
    import codec_pkg::*;
#(
    parameter int ADDR_W = CODEC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic [7:0]        data_i,
    input  logic              release_i,
    output logic              busy_o,
    output codec_cmd_t        cmd_o
);

    logic       busy_q, busy_d;
    codec_cmd_t cmd_q,  cmd_d;

    // Next-state: release wins, otherwise an idle port accepts a pulse (read wins a tie).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        busy_d = busy_q;
        cmd_d  = cmd_q;
        if (release_i) begin
            busy_d = 1'b0;
        end else if (!busy_q && (rd_en_i || wr_en_i)) begin
            busy_d     = 1'b1;
            cmd_d.rd   = rd_en_i;
            cmd_d.addr = CODEC_ADDR_W'(reg_addr_i);
            cmd_d.data = data_i;
        end
    end

    // Pending flag and command register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            busy_q <= 1'b0;
            cmd_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cmd_q  <= cmd_d;
        end
    end

    assign busy_o = busy_q;
    assign cmd_o  = cmd_q;

endmodule

// File: rtl/codec_access_arbiter.sv
// codec_access_arbiter: shares one codec I2C register controller between the
// codec init unit (port 0) and the software register path (port 1).
// Round-robin between pending ports, one transaction in flight at a time.
// Optional watchdog: define CODEC_ARB_TIMEOUT_EN to abort stuck transactions
// after TIMEOUT_CYCLES and report them with pN_error.
module codec_access_arbiter
    import codec_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = CODEC_TIMEOUT_DEFAULT,
    parameter int          ADDR_W         = CODEC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    // port 0: codec init unit
    input  logic              p0_rd_en,
    input  logic              p0_wr_en,
    input  logic [ADDR_W-1:0] p0_reg_addr,
    input  logic [7:0]        p0_data_out,
    output logic [7:0]        p0_data_in,
    output logic              p0_data_in_valid,
    output logic              p0_done,
    output logic              p0_error,
    output logic              p0_busy,
    // port 1: software register path
    input  logic              p1_rd_en,
    input  logic              p1_wr_en,
    input  logic [ADDR_W-1:0] p1_reg_addr,
    input  logic [7:0]        p1_data_out,
    output logic [7:0]        p1_data_in,
    output logic              p1_data_in_valid,
    output logic              p1_done,
    output logic              p1_error,
    output logic              p1_busy,
    // I2C register controller
    output logic              codec_rd_en,
    output logic              codec_wr_en,
    output logic [ADDR_W-1:0] codec_reg_addr,
    output logic [7:0]        codec_data_out,
    input  logic [7:0]        codec_data_in,
    input  logic              codec_data_in_valid,
    input  logic              controller_busy
);

    logic [1:0]        pend_busy;
    codec_cmd_t        pend_cmd [2];
    logic [1:0]        release_w;

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;   // port currently being served
    logic              rr_q,    rr_d;      // port that wins a tie next time
    logic              rd_q,    rd_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [1:0][7:0]   rdata_q, rdata_d;   // per-port read data, held until that port's next read
    logic              gnt;
    logic              resp_timeout;

    codec_req_latch #(.ADDR_W(ADDR_W)) u_req_p0 (
        .clk        (clk),
        .reset      (reset),
        .rd_en_i    (p0_rd_en),
        .wr_en_i    (p0_wr_en),
        .reg_addr_i (p0_reg_addr),
        .data_i     (p0_data_out),
        .release_i  (release_w[0]),
        .busy_o     (pend_busy[0]),
        .cmd_o      (pend_cmd[0])
    );

    codec_req_latch #(.ADDR_W(ADDR_W)) u_req_p1 (
        .clk        (clk),
        .reset      (reset),
        .rd_en_i    (p1_rd_en),
        .wr_en_i    (p1_wr_en),
        .reg_addr_i (p1_reg_addr),
        .data_i     (p1_data_out),
        .release_i  (release_w[1]),
        .busy_o     (pend_busy[1]),
        .cmd_o      (pend_cmd[1])
    );

    // The owner is released (busy falls) on the edge that ends RESP.
    assign release_w[0] = (state_q == ST_RESP) && (owner_q == 1'b0);
    assign release_w[1] = (state_q == ST_RESP) && (owner_q == 1'b1);

`ifdef CODEC_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        to_q, to_d;
    logic        wd_expired;

    // The counter reads TIMEOUT_CYCLES-1 in the last allowed wait cycle.
    assign wd_expired   = (wd_q == TIMEOUT_CYCLES - 16'd1);
    assign resp_timeout = to_q;
`else
    assign resp_timeout = 1'b0;
`endif

    // Next-state, grant and capture logic of the arbiter FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt     = 1'b0;
`ifdef CODEC_ARB_TIMEOUT_EN
        wd_d    = wd_q;
        to_d    = to_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pend_busy != 2'b00) begin
                    // Tie goes to the port not granted last; a lone requester always wins.
                    gnt     = (pend_busy == 2'b11) ? rr_q : pend_busy[1];
                    owner_d = gnt;
                    rr_d    = ~gnt;
                    rd_d    = pend_cmd[gnt].rd;
                    addr_d  = ADDR_W'(pend_cmd[gnt].addr);
                    wdata_d = pend_cmd[gnt].data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
`ifdef CODEC_ARB_TIMEOUT_EN
                wd_d    = '0;
                to_d    = 1'b0;
`endif
            end
            ST_WAIT_BUSY: begin
`ifdef CODEC_ARB_TIMEOUT_EN
                wd_d = wd_q + 16'd1;
`endif
                if (controller_busy) begin
                    state_d = ST_WAIT_DONE;
`ifdef CODEC_ARB_TIMEOUT_EN
                end else if (wd_expired) begin
                    state_d = ST_RESP;
                    to_d    = 1'b1;
`endif
                end
            end
            ST_WAIT_DONE: begin
`ifdef CODEC_ARB_TIMEOUT_EN
                wd_d = wd_q + 16'd1;
`endif
                if (rd_q && codec_data_in_valid) begin
                    state_d          = ST_RESP;
                    rdata_d[owner_q] = codec_data_in;
                end else if (!rd_q && !controller_busy) begin
                    state_d = ST_RESP;
`ifdef CODEC_ARB_TIMEOUT_EN
                end else if (wd_expired) begin
                    state_d = ST_RESP;
                    to_d    = 1'b1;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, current transaction and per-port read data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef CODEC_ARB_TIMEOUT_EN
    // Watchdog counter and the timed-out flag reported in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
`endif

    // Controller strobes last exactly the ISSUE cycle; address/data are held in registers.
    assign codec_rd_en      = (state_q == ST_ISSUE) &&  rd_q;
    assign codec_wr_en      = (state_q == ST_ISSUE) && !rd_q;
    assign codec_reg_addr   = addr_q;
    assign codec_data_out   = wdata_q;

    assign p0_busy          = pend_busy[0];
    assign p0_done          = release_w[0];
    assign p0_data_in_valid = release_w[0] && rd_q && !resp_timeout;
    assign p0_error         = release_w[0] && resp_timeout;
    assign p0_data_in       = rdata_q[0];

    assign p1_busy          = pend_busy[1];
    assign p1_done          = release_w[1];
    assign p1_data_in_valid = release_w[1] && rd_q && !resp_timeout;
    assign p1_error         = release_w[1] && resp_timeout;
    assign p1_data_in       = rdata_q[1];

endmodule

// File: tb/tb_codec_access_arbiter.sv
// tb_codec_access_arbiter: randomized bench with a transaction-level reference
// model and a behavioural I2C controller. Build with CODEC_ARB_TIMEOUT_EN to
// also exercise the watchdog.
`timescale 1ns/1ps
module tb_codec_access_arbiter;
    import codec_pkg::*;

    localparam logic [15:0] TB_TO = 16'd20;
    localparam int          AW    = CODEC_ADDR_W;
`ifdef CODEC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [1:0]         req_rd, req_wr;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][7:0]    req_data;
    logic [1:0][7:0]    dut_rdata;
    logic [1:0]         dut_valid, dut_done, dut_err, dut_busy;
    logic               codec_rd_en, codec_wr_en;
    logic [AW-1:0]      codec_reg_addr;
    logic [7:0]         codec_data_out, codec_data_in;
    logic               codec_data_in_valid, controller_busy;

    always #5 clk = ~clk;

    codec_access_arbiter #(.TIMEOUT_CYCLES(TB_TO), .ADDR_W(AW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .p0_rd_en            (req_rd[0]),
        .p0_wr_en            (req_wr[0]),
        .p0_reg_addr         (req_addr[0]),
        .p0_data_out         (req_data[0]),
        .p0_data_in          (dut_rdata[0]),
        .p0_data_in_valid    (dut_valid[0]),
        .p0_done             (dut_done[0]),
        .p0_error            (dut_err[0]),
        .p0_busy             (dut_busy[0]),
        .p1_rd_en            (req_rd[1]),
        .p1_wr_en            (req_wr[1]),
        .p1_reg_addr         (req_addr[1]),
        .p1_data_out         (req_data[1]),
        .p1_data_in          (dut_rdata[1]),
        .p1_data_in_valid    (dut_valid[1]),
        .p1_done             (dut_done[1]),
        .p1_error            (dut_err[1]),
        .p1_busy             (dut_busy[1]),
        .codec_rd_en         (codec_rd_en),
        .codec_wr_en         (codec_wr_en),
        .codec_reg_addr      (codec_reg_addr),
        .codec_data_out      (codec_data_out),
        .codec_data_in       (codec_data_in),
        .codec_data_in_valid (codec_data_in_valid),
        .controller_busy     (controller_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model state (transaction level) ----------------
    bit            checking = 1'b0;
    bit            m_busy [2];
    bit            m_rd   [2];
    logic [AW-1:0] m_addr [2];
    logic [7:0]    m_wdata[2];
    logic [7:0]    m_data [2];
    bit            m_pref;              // port that wins when both wait
    bit            m_inflight;
    int            m_owner;
    int            due_cyc  = -10;      // cycle the controller strobe must appear
    int            resp_cyc = -10;      // cycle the owner must see done
    bit            o_rd, o_to;
    logic [AW-1:0] o_addr;
    logic [7:0]    o_wdata, o_rdata;

    // ---------------- behavioural controller ----------------
    int            bfm_b    = -100;     // first cycle controller_busy is high
    int            bfm_comp = -100;     // completion cycle (busy low, read data valid)
    bit            bfm_rd;
    logic [7:0]    bfm_rdata;
    bit            bfm_dead = 1'b0;     // never responds
    int            force_d0 = -1, force_l = -1, force_data = -1;

    int            last_strobe_cyc = -1;
    int            err_cyc         = -1;
    int            done_log[$];

    // Observe, compare against the model, then advance the model one cycle.
    always @(negedge clk) begin
        bit nb [2];
        bit is_resp;
        int d0, len;
        if (checking) begin
            for (int p = 0; p < 2; p++) begin
                is_resp = m_inflight && (cyc == resp_cyc) && (m_owner == p);
                check($sformatf("p%0d_busy", p),  dut_busy[p],  m_busy[p]);
                check($sformatf("p%0d_done", p),  dut_done[p],  is_resp);
                check($sformatf("p%0d_valid", p), dut_valid[p], is_resp && o_rd && !o_to);
                check($sformatf("p%0d_error", p), dut_err[p],   is_resp && o_to);
                check($sformatf("p%0d_data_in", p), dut_rdata[p], m_data[p]);
            end
            check("codec_rd_en", codec_rd_en, m_inflight && (cyc == due_cyc) &&  o_rd);
            check("codec_wr_en", codec_wr_en, m_inflight && (cyc == due_cyc) && !o_rd);
            if (m_inflight && cyc >= due_cyc && cyc <= resp_cyc) begin
                check("codec_reg_addr", codec_reg_addr, o_addr);
                check("codec_data_out", codec_data_out, o_wdata);
            end
        end
        for (int p = 0; p < 2; p++) if (dut_done[p]) done_log.push_back(p);
        if (dut_err[1]) err_cyc = cyc;

        // controller reacts to the strobe it actually sees
        if (codec_rd_en || codec_wr_en) begin
            last_strobe_cyc = cyc;
            if (!bfm_dead) begin
                d0        = (force_d0 >= 0) ? force_d0 : $urandom_range(0, 2);
                len       = (force_l  >= 0) ? force_l  : $urandom_range(1, 6);
                bfm_rdata = (force_data >= 0) ? force_data[7:0] : 8'($urandom);
                bfm_rd    = codec_rd_en;
                bfm_b     = cyc + 1 + d0;
                bfm_comp  = bfm_b + len;
                if (m_inflight) begin
                    resp_cyc = bfm_comp + 1;
                    o_rdata  = bfm_rdata;
                    o_to     = 1'b0;
                end
            end
        end

        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                m_busy[p] = 1'b0;
                m_data[p] = 8'h00;
            end
            m_inflight = 1'b0;
            m_pref     = 1'b0;
            due_cyc    = -10;
            resp_cyc   = -10;
            bfm_b      = -100;
            bfm_comp   = -100;
            checking   = 1'b1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                nb[p] = m_busy[p];
                if (!m_busy[p] && (req_rd[p] || req_wr[p])) begin
                    nb[p]      = 1'b1;
                    m_rd[p]    = req_rd[p];
                    m_addr[p]  = req_addr[p];
                    m_wdata[p] = req_data[p];
                end
            end
            if (m_inflight && cyc == resp_cyc) begin
                nb[m_owner] = 1'b0;
                m_inflight  = 1'b0;
            end else if (!m_inflight && (m_busy[0] || m_busy[1])) begin
                m_owner    = (m_busy[0] && m_busy[1]) ? int'(m_pref) : (m_busy[1] ? 1 : 0);
                m_pref     = (m_owner == 0);
                o_rd       = m_rd[m_owner];
                o_addr     = m_addr[m_owner];
                o_wdata    = m_wdata[m_owner];
                o_to       = TO_EN;
                due_cyc    = cyc + 1;
                resp_cyc   = TO_EN ? (due_cyc + int'(TB_TO) + 1) : 32'h3fff_ffff;
                m_inflight = 1'b1;
            end else if (m_inflight && cyc + 1 == resp_cyc && o_rd && !o_to) begin
                m_data[m_owner] = o_rdata;
            end
            for (int p = 0; p < 2; p++) m_busy[p] = nb[p];
        end
    end

    // Controller pin drive, plus stray valid pulses the arbiter must ignore.
    always @(posedge clk) begin
        #1;
        controller_busy     = (cyc >= bfm_b) && (cyc < bfm_comp);
        codec_data_in_valid = 1'b0;
        codec_data_in       = 8'($urandom);
        if (cyc == bfm_comp) begin
            codec_data_in_valid = bfm_rd || ($urandom_range(0, 1) == 1);
            if (bfm_rd) codec_data_in = bfm_rdata;
        end else if (!(cyc >= bfm_b && cyc <= bfm_comp) && !bfm_dead && $urandom_range(0, 7) == 0) begin
            codec_data_in_valid = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        req_rd = '0;
        req_wr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while ((m_busy[0] || m_busy[1] || m_inflight) && n < limit) begin
            step();
            n++;
        end
        check({tag, "_drain"}, (n < limit), 1);
    endtask

    int t_req, n_log, cnt;
    int issued [2];

    initial begin
        reset = 1'b1;
        req_rd = '0; req_wr = '0; req_addr = '0; req_data = '0;
        controller_busy = 1'b0; codec_data_in_valid = 1'b0; codec_data_in = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        check("rst_addr",  codec_reg_addr, '0);
        check("rst_rd_en", codec_rd_en, 0);
        check("rst_data0", dut_rdata[0], 8'h00);
        step();

        // p0 read of 0x000, controller busy 10 cycles then returns 0x17
        force_d0 = 0; force_l = 10; force_data = 8'h17;
        t_req = cyc;
        req_rd[0] = 1'b1; req_addr[0] = CODEC_REG_CHIP_ID;
        step();
        wait_idle(100, "basic_rd");
        check("basic_strobe_lat", last_strobe_cyc - t_req, 2);
        check("basic_data", dut_rdata[0], 8'h17);
        check("basic_done_port", done_log[$], 0);
        force_d0 = -1; force_l = -1; force_data = -1;

        // simultaneous p0 write / p1 read from reset: p0 first
        do_reset();
        done_log.delete();
        req_wr[0] = 1'b1; req_addr[0] = CODEC_REG_POWER;   req_data[0] = 8'h12;
        req_rd[1] = 1'b1; req_addr[1] = CODEC_REG_DAC_VOL; req_data[1] = 8'h5a;
        step();
        wait_idle(100, "dual");
        check("dual_count", done_log.size(), 2);
        check("dual_first", done_log[0], 0);
        check("dual_second", done_log[1], 1);

        // back-to-back on both ports: strict alternation
        done_log.delete();
        issued[0] = 0; issued[1] = 0; cnt = 0;
        while ((issued[0] < 4 || issued[1] < 4 || m_inflight || m_busy[0] || m_busy[1]) && cnt < 400) begin
            for (int p = 0; p < 2; p++) begin
                if (!m_busy[p] && issued[p] < 4) begin
                    req_rd[p]   = $urandom_range(0, 1) == 1;
                    req_wr[p]   = !req_rd[p];
                    req_addr[p] = AW'($urandom);
                    req_data[p] = 8'($urandom);
                    issued[p]++;
                end
            end
            step();
            cnt++;
        end
        check("rr_bound", (cnt < 400), 1);
        check("rr_count", done_log.size(), 8);
        for (int i = 1; i < done_log.size(); i++)
            check($sformatf("rr_alt%0d", i), done_log[i], done_log[i-1] ^ 1);

        // random traffic, including pulses while busy and rd+wr together
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 5) == 0) begin
                    req_rd[p]   = $urandom_range(0, 1) == 1;
                    req_wr[p]   = $urandom_range(0, 1) == 1;
                    req_addr[p] = AW'($urandom);
                    req_data[p] = 8'($urandom);
                end
            end
            step();
        end
        wait_idle(200, "random");

        // reset in WAIT_DONE of a p0 read: no done, then p1 served normally
        do_reset();
        force_d0 = 0; force_l = 8;
        req_rd[0] = 1'b1; req_addr[0] = CODEC_REG_ADC_VOL;
        step();
        cnt = 0;
        while (!(m_inflight && cyc == bfm_b + 3) && cnt < 50) begin
            step();
            cnt++;
        end
        check("abort_reach", (cnt < 50), 1);
        n_log = done_log.size();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy0", dut_busy[0], 0);
        check("abort_rd_en", codec_rd_en, 0);
        check("abort_addr",  codec_reg_addr, '0);
        force_d0 = -1; force_l = -1;
        step();
        req_rd[1] = 1'b1; req_addr[1] = CODEC_REG_SOFT_RST;
        step();
        wait_idle(100, "abort_p1");
        check("abort_no_done", done_log.size(), n_log + 1);
        check("abort_p1_done", done_log[$], 1);

`ifdef CODEC_ARB_TIMEOUT_EN
        // dead controller: watchdog ends the transaction with error
        bfm_dead = 1'b1;
        err_cyc  = -1;
        req_rd[1] = 1'b1; req_addr[1] = CODEC_REG_DAC_VOL;
        step();
        wait_idle(100, "timeout");
        check("timeout_lat", err_cyc - last_strobe_cyc, 21);
        bfm_dead = 1'b0;
`endif

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

endmodule
